// File: rtl/serial_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : serial_normalizer
// Description : Converts a 12-bit two's-complement sample into sign, 3-bit
//               exponent, 4-bit significand and round bit. The leading one is
//               found by shifting the magnitude left one place per clock.
//               Valid/ready handshakes on input and output.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_normalizer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] d_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        sign_out,
    output logic [2:0]  e_output,
    output logic [3:0]  f_output,
    output logic        fifth_bit,
    output logic        out_valid,
    input  logic        out_ready
);

    // Shift budget is tied to the 3-bit exponent range.
    localparam logic [3:0] MAX_SHIFT = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        sign;
    logic [11:0] mag;
    logic [3:0]  s;
    logic [11:0] mag_in;
    logic        norm_done;

    // Absolute value of the incoming sample; the most-negative code has no
    // positive counterpart and clamps to the largest positive magnitude.
    always_comb begin
        mag_in = d_in;
        if (d_in == 12'h800) begin
            mag_in = 12'h7FF;
        end else if (d_in[11]) begin
            mag_in = ~d_in + 12'd1;
        end
    end

    // Normalisation ends on a leading one or when the shift budget runs out.
    assign norm_done = mag[11] || (s == MAX_SHIFT);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = NORM;
            NORM:    if (norm_done) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture on accept, shift while normalising, latch results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign      <= 1'b0;
            mag       <= 12'd0;
            s         <= 4'd0;
            sign_out  <= 1'b0;
            e_output  <= 3'd0;
            f_output  <= 4'd0;
            fifth_bit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign <= d_in[11];
                        mag  <= mag_in;
                        s    <= 4'd0;
                    end
                end
                NORM: begin
                    if (norm_done) begin
                        // 8 - s modulo 8 equals -s on the low three bits,
                        // so s = 8 lands on exponent 0 (denormal).
                        e_output  <= 3'd0 - s[2:0];
                        f_output  <= mag[11:8];
                        fifth_bit <= mag[7];
                        sign_out  <= sign;
                    end else begin
                        mag <= {mag[10:0], 1'b0};
                        s   <= s + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_normalizer
// Description : Directed self-checking bench for serial_normalizer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_normalizer;

    logic        clk;
    logic        rst_n;
    logic [11:0] d_in;
    logic        in_valid;
    logic        in_ready;
    logic        sign_out;
    logic [2:0]  e_output;
    logic [3:0]  f_output;
    logic        fifth_bit;
    logic        out_valid;
    logic        out_ready;

    int vectors;
    int miscompares;

    serial_normalizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_in      (d_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_out  (sign_out),
        .e_output  (e_output),
        .f_output  (f_output),
        .fifth_bit (fifth_bit),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic s, input logic [2:0] e,
                               input logic [3:0] f, input logic fb);
        chk({tag, ".sign"},  {11'd0, sign_out}, {11'd0, s});
        chk({tag, ".e"},     {9'd0, e_output},  {9'd0, e});
        chk({tag, ".f"},     {8'd0, f_output},  {8'd0, f});
        chk({tag, ".fifth"}, {11'd0, fifth_bit}, {11'd0, fb});
    endtask

    // Present one sample, count cycles to out_valid (bounded) and check results.
    // Returns at the negedge where out_valid was first seen high.
    task automatic launch(input string tag, input logic [11:0] d, input int exp_lat,
                          input logic s, input logic [2:0] e, input logic [3:0] f,
                          input logic fb);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready"}, {11'd0, in_ready}, 12'd1);
        d_in     = d;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        d_in     = ~d;  // must not affect the sample in flight
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, ".latency"}, lat[11:0], exp_lat[11:0]);
        chk_outputs(tag, s, e, f, fb);
    endtask

    // Hand off the result for one cycle and check return to IDLE.
    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".out_valid_fall"}, {11'd0, out_valid}, 12'd0);
        chk({tag, ".in_ready_rise"},  {11'd0, in_ready},  12'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        d_in        = 12'd0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;

        // Reset state.
        #12;
        chk("rst.in_ready",  {11'd0, in_ready},  12'd1);
        chk("rst.out_valid", {11'd0, out_valid}, 12'd0);
        chk_outputs("rst", 1'b0, 3'd0, 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // out_ready while idle has no effect.
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_ready.out_valid", {11'd0, out_valid}, 12'd0);

        // Positive: 0x07D, five leading zeros.
        launch("pos07D", 12'h07D, 6, 1'b0, 3'd3, 4'hF, 1'b1);
        consume("pos07D");

        // Most negative clamps to 0x7FF.
        launch("neg800", 12'h800, 2, 1'b1, 3'd7, 4'hF, 1'b1);
        consume("neg800");

        // -1: denormal.
        launch("negFFF", 12'hFFF, 9, 1'b1, 3'd0, 4'h1, 1'b0);
        consume("negFFF");

        // Zero.
        launch("zero", 12'h000, 9, 1'b0, 3'd0, 4'h0, 1'b0);
        consume("zero");

        // Small magnitude below 16 is carried exactly.
        launch("small00A", 12'h00A, 9, 1'b0, 3'd0, 4'hA, 1'b0);
        consume("small00A");

        // Backpressure: hold for five cycles, stray in_valid ignored.
        launch("bp400", 12'h400, 2, 1'b0, 3'd7, 4'h8, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                d_in     = 12'h123;
                in_valid = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            chk("bp.out_valid", {11'd0, out_valid}, 12'd1);
            chk("bp.in_ready",  {11'd0, in_ready},  12'd0);
            chk_outputs("bp.hold", 1'b0, 3'd7, 4'h8, 1'b0);
        end
        // Handoff with in_valid high: no accept in the handoff cycle.
        d_in     = 12'h123;
        in_valid = 1'b1;
        consume("bp");
        in_valid = 1'b0;
        chk_outputs("bp.kept", 1'b0, 3'd7, 4'h8, 1'b0);

        // Reset in the middle of normalisation.
        @(negedge clk);
        d_in     = 12'h001;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", {11'd0, out_valid}, 12'd0);
        chk("midrst.in_ready",  {11'd0, in_ready},  12'd1);
        chk_outputs("midrst", 1'b0, 3'd0, 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        // No pulse from the discarded sample.
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            chk("midrst.no_pulse", {11'd0, out_valid}, 12'd0);
        end
        launch("post7FF", 12'h7FF, 2, 1'b0, 3'd7, 4'hF, 1'b1);
        consume("post7FF");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
